// File: rtl/hazard_unit_pkg.sv
// hazard_unit_pkg
//   Shared encodings for the pipeline hazard controller:
//   - forwarding select codes for the E-stage operand muxes
//   - memory-wait FSM state codes
//   - reg_match(): register-index compare that never matches x0
package hazard_unit_pkg;

  // E-stage operand select encodings
  localparam logic [1:0] FWD_REG = 2'b00;  // register file value
  localparam logic [1:0] FWD_W   = 2'b01;  // W-stage result
  localparam logic [1:0] FWD_M   = 2'b10;  // M-stage ALU output

  // Memory-wait FSM state codes
  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  // x0 is hard-wired to zero, so a write to it can never feed a reader.
  function automatic logic reg_match(input logic [4:0] dst, input logic [4:0] src);
    return (dst != 5'd0) && (dst == src);
  endfunction

endpackage

// File: rtl/hazard_unit_sat_counter.sv
// sat_counter
//   Event counter that increments on inc and holds at all-ones.
//   Ports:
//     clk  - clock
//     rstn - synchronous active-low reset, clears the count
//     inc  - count this cycle
//     q    - current count (W bits)
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_q <= '0;
    end else if (inc && (r_q != {W{1'b1}})) begin
      r_q <= r_q + 1'b1;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit
//   Hazard controller for the five-stage RV32 pipeline. Produces forwarding
//   selects for E and D, stalls/flushes for load-use, branch-in-decode and
//   taken-branch cases, freezes the pipe while data memory is not ready,
//   flags memory timeouts and keeps saturating stall/flush counters.
//   Ports:
//     clk, rstn                      - clock, synchronous active-low reset
//     rs1D..rdW                      - register indices per stage
//     regWriteE/M/W, memToRegE/M     - producer info per stage
//     branchD, jalrD, pcSrcD         - decode-stage control-flow info
//     memReqM, memReadyM             - data memory handshake
//     forwardAE/BE, forwardAD/BD     - operand forwarding selects
//     stallF/D/E/M, flushD/E/W       - pipeline register hold/clear
//     memErr                         - sticky memory-timeout flag
//     stallCnt, flushCnt             - saturating event counters
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [4:0]       rs1D,
  input  logic [4:0]       rs2D,
  input  logic [4:0]       rs1E,
  input  logic [4:0]       rs2E,
  input  logic [4:0]       rdE,
  input  logic [4:0]       rdM,
  input  logic [4:0]       rdW,
  input  logic             regWriteE,
  input  logic             regWriteM,
  input  logic             regWriteW,
  input  logic             memToRegE,
  input  logic             memToRegM,
  input  logic             branchD,
  input  logic             jalrD,
  input  logic             pcSrcD,
  input  logic             memReqM,
  input  logic             memReadyM,
  output logic [1:0]       forwardAE,
  output logic [1:0]       forwardBE,
  output logic             forwardAD,
  output logic             forwardBD,
  output logic             stallF,
  output logic             stallD,
  output logic             stallE,
  output logic             stallM,
  output logic             flushD,
  output logic             flushE,
  output logic             flushW,
  output logic             memErr,
  output logic [CNT_W-1:0] stallCnt,
  output logic [CNT_W-1:0] flushCnt
);

  localparam int            TW   = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

  logic [0:0]    r_state;
  logic [0:0]    w_state_next;
  logic [TW-1:0] r_timer;
  logic [TW-1:0] w_timer_next;
  logic          r_mem_err;

  logic w_mem_wait;
  logic w_ld_stall;
  logic w_br_stall;
  logic w_haz_stall;
  logic w_br_e_match;
  logic w_br_m_match;

  // ---------------- forwarding ----------------
  always_comb begin
    forwardAE = FWD_REG;
    if (regWriteM && reg_match(rdM, rs1E))      forwardAE = FWD_M;
    else if (regWriteW && reg_match(rdW, rs1E)) forwardAE = FWD_W;

    forwardBE = FWD_REG;
    if (regWriteM && reg_match(rdM, rs2E))      forwardBE = FWD_M;
    else if (regWriteW && reg_match(rdW, rs2E)) forwardBE = FWD_W;
  end

  assign forwardAD = regWriteM && reg_match(rdM, rs1D);
  assign forwardBD = regWriteM && reg_match(rdM, rs2D);

  // ---------------- hazard detection ----------------
  assign w_ld_stall = memToRegE && (reg_match(rdE, rs1D) || reg_match(rdE, rs2D));

  // jalr only reads rs1 in decode; conditional branches read both sources.
  assign w_br_e_match = regWriteE && (reg_match(rdE, rs1D) || (branchD && reg_match(rdE, rs2D)));
  assign w_br_m_match = memToRegM && (reg_match(rdM, rs1D) || (branchD && reg_match(rdM, rs2D)));
  assign w_br_stall   = (branchD || jalrD) && (w_br_e_match || w_br_m_match);

  assign w_haz_stall = w_ld_stall || w_br_stall;

  // Combinational so the very first miss cycle already freezes the pipe.
  assign w_mem_wait = memReqM && !memReadyM;

  // A memory wait overrides hazard handling; the hazard inputs stay put while
  // frozen, so their stall/flush naturally happens once the wait ends.
  assign stallF = w_mem_wait || w_haz_stall;
  assign stallD = w_mem_wait || w_haz_stall;
  assign stallE = w_mem_wait;
  assign stallM = w_mem_wait;
  assign flushW = w_mem_wait;
  assign flushE = !w_mem_wait && w_haz_stall;
  assign flushD = !w_mem_wait && !w_haz_stall && pcSrcD;

  // ---------------- memory-wait FSM and timer ----------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RUN:  if (w_mem_wait) w_state_next = ST_WAIT;
      ST_WAIT: if (memReadyM)  w_state_next = ST_RUN;
      default: w_state_next = ST_RUN;
    endcase
  end

  // Timer counts cycles spent in WAIT and holds at TIMEOUT so it cannot wrap.
  always_comb begin
    w_timer_next = r_timer;
    if (w_state_next == ST_RUN) begin
      w_timer_next = '0;
    end else if ((r_state == ST_WAIT) && (r_timer != TMAX)) begin
      w_timer_next = r_timer + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state   <= ST_RUN;
      r_timer   <= '0;
      r_mem_err <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_timer   <= w_timer_next;
      if (w_timer_next == TMAX) r_mem_err <= 1'b1;
    end
  end

  assign memErr = r_mem_err;

  // ---------------- performance counters ----------------
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk  (clk),
    .rstn (rstn),
    .inc  (stallF),
    .q    (stallCnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk  (clk),
    .rstn (rstn),
    .inc  (flushD || flushE),
    .q    (flushCnt)
  );

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit
//   Directed-vector bench. Two instances share the same stimulus:
//   u_a uses default parameters, u_b uses CNT_W=4 / TIMEOUT=4 to reach the
//   timeout and counter-saturation corners quickly.
module tb_hazard_unit;
  import hazard_unit_pkg::*;

  logic clk = 1'b0;
  logic rstn;
  logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
  logic regWriteE, regWriteM, regWriteW, memToRegE, memToRegM;
  logic branchD, jalrD, pcSrcD, memReqM, memReadyM;

  logic [1:0]  a_fAE, a_fBE;
  logic        a_fAD, a_fBD, a_sF, a_sD, a_sE, a_sM, a_flD, a_flE, a_flW, a_err;
  logic [31:0] a_sCnt, a_fCnt;

  logic [1:0]  b_fAE, b_fBE;
  logic        b_fAD, b_fBD, b_sF, b_sD, b_sE, b_sM, b_flD, b_flE, b_flW, b_err;
  logic [3:0]  b_sCnt, b_fCnt;

  int err_cnt = 0;
  int chk_cnt = 0;

  always #5 clk = ~clk;

  hazard_unit u_a (
    .clk(clk), .rstn(rstn),
    .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
    .rdE(rdE), .rdM(rdM), .rdW(rdW),
    .regWriteE(regWriteE), .regWriteM(regWriteM), .regWriteW(regWriteW),
    .memToRegE(memToRegE), .memToRegM(memToRegM),
    .branchD(branchD), .jalrD(jalrD), .pcSrcD(pcSrcD),
    .memReqM(memReqM), .memReadyM(memReadyM),
    .forwardAE(a_fAE), .forwardBE(a_fBE), .forwardAD(a_fAD), .forwardBD(a_fBD),
    .stallF(a_sF), .stallD(a_sD), .stallE(a_sE), .stallM(a_sM),
    .flushD(a_flD), .flushE(a_flE), .flushW(a_flW),
    .memErr(a_err), .stallCnt(a_sCnt), .flushCnt(a_fCnt)
  );

  hazard_unit #(.CNT_W(4), .TIMEOUT(4)) u_b (
    .clk(clk), .rstn(rstn),
    .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
    .rdE(rdE), .rdM(rdM), .rdW(rdW),
    .regWriteE(regWriteE), .regWriteM(regWriteM), .regWriteW(regWriteW),
    .memToRegE(memToRegE), .memToRegM(memToRegM),
    .branchD(branchD), .jalrD(jalrD), .pcSrcD(pcSrcD),
    .memReqM(memReqM), .memReadyM(memReadyM),
    .forwardAE(b_fAE), .forwardBE(b_fBE), .forwardAD(b_fAD), .forwardBD(b_fBD),
    .stallF(b_sF), .stallD(b_sD), .stallE(b_sE), .stallM(b_sM),
    .flushD(b_flD), .flushE(b_flE), .flushW(b_flW),
    .memErr(b_err), .stallCnt(b_sCnt), .flushCnt(b_fCnt)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end else begin
      $display("ok   %s: %0h", tag, act);
    end
  endtask

  task automatic idle();
    rs1D = 0; rs2D = 0; rs1E = 0; rs2E = 0; rdE = 0; rdM = 0; rdW = 0;
    regWriteE = 0; regWriteM = 0; regWriteW = 0; memToRegE = 0; memToRegM = 0;
    branchD = 0; jalrD = 0; pcSrcD = 0; memReqM = 0; memReadyM = 0;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rstn = 1'b0;
    idle();
    tick();
    rstn = 1'b1;
    settle();

    // ---- reset state ----
    chk("rst_stallF", a_sF, 0);
    chk("rst_flushD", a_flD, 0);
    chk("rst_flushE", a_flE, 0);
    chk("rst_flushW", a_flW, 0);
    chk("rst_stallM", a_sM, 0);
    chk("rst_memErr", a_err, 0);
    chk("rst_stallCnt", a_sCnt, 0);
    chk("rst_flushCnt", a_fCnt, 0);
    chk("rst_state", 32'(u_a.r_state), 32'(ST_RUN));

    // ---- load-use ----
    memToRegE = 1; regWriteE = 1; rdE = 5; rs1D = 5; rs2D = 1; settle();
    chk("ld_stallF", a_sF, 1);
    chk("ld_stallD", a_sD, 1);
    chk("ld_flushE", a_flE, 1);
    chk("ld_stallE", a_sE, 0);
    chk("ld_flushD", a_flD, 0);
    tick();
    memToRegE = 0; regWriteE = 0; rdE = 0; rs1D = 0; rs2D = 0;
    memToRegM = 1; regWriteM = 1; rdM = 5; rs1E = 5; settle();
    chk("ld_fwdAE", a_fAE, 2'b10);
    chk("ld_after_stallF", a_sF, 0);
    chk("ld_stallCnt", a_sCnt, 1);
    chk("ld_flushCnt", a_fCnt, 1);
    idle();

    // ---- E forwarding priority ----
    rdM = 7; rdW = 7; regWriteM = 1; regWriteW = 1; rs2E = 7; settle();
    chk("fwdBE_M", a_fBE, 2'b10);
    chk("fwdAE_none", a_fAE, 2'b00);
    regWriteM = 0; settle();
    chk("fwdBE_W", a_fBE, 2'b01);
    regWriteM = 1; rs2E = 0; rdM = 0; settle();
    chk("fwdBE_x0", a_fBE, 2'b00);
    rdW = 0; settle();
    chk("fwdBE_x0W", a_fBE, 2'b00);
    idle();

    // ---- branch after load: 2 bubbles ----
    branchD = 1; rs1D = 3; rs2D = 4; memToRegE = 1; regWriteE = 1; rdE = 3; settle();
    chk("brld1_stallF", a_sF, 1);
    tick();
    memToRegE = 0; regWriteE = 0; rdE = 0;
    memToRegM = 1; regWriteM = 1; rdM = 3; settle();
    chk("brld2_stallF", a_sF, 1);
    chk("brld2_flushE", a_flE, 1);
    tick();
    memToRegM = 0; regWriteM = 0; rdM = 0; regWriteW = 1; rdW = 3; settle();
    chk("brld3_stallF", a_sF, 0);
    chk("brld3_fwdAD", a_fAD, 0);
    chk("brld_stallCnt", a_sCnt, 3);
    idle();

    // ---- branch after ALU op: 1 bubble ----
    branchD = 1; rs1D = 3; rs2D = 4; regWriteE = 1; rdE = 3; settle();
    chk("bralu1_stallF", a_sF, 1);
    tick();
    regWriteE = 0; rdE = 0; regWriteM = 1; rdM = 3; settle();
    chk("bralu2_stallF", a_sF, 0);
    chk("bralu2_fwdAD", a_fAD, 1);
    chk("bralu2_fwdBD", a_fBD, 0);
    chk("bralu_stallCnt", a_sCnt, 4);
    chk("bralu_flushCnt", a_fCnt, 4);
    idle();

    // ---- jalr checks rs1 only ----
    jalrD = 1; rs1D = 3; rs2D = 4; regWriteE = 1; rdE = 4; settle();
    chk("jalr_rs2_stallF", a_sF, 0);
    rdE = 3; settle();
    chk("jalr_rs1_stallF", a_sF, 1);
    idle();

    // ---- taken branch ----
    pcSrcD = 1; settle();
    chk("taken_flushD", a_flD, 1);
    chk("taken_stallF", a_sF, 0);
    tick();
    pcSrcD = 0; settle();
    chk("taken_off_flushD", a_flD, 0);
    chk("taken_flushCnt", a_fCnt, 5);
    pcSrcD = 1; memToRegE = 1; rdE = 5; rs1D = 5; settle();
    chk("taken_ld_flushD", a_flD, 0);
    chk("taken_ld_flushE", a_flE, 1);
    idle();

    // ---- memory wait, 3 cycles ----
    memReqM = 1; memReadyM = 0; pcSrcD = 1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk($sformatf("mw%0d_stall", i), {a_sF, a_sD, a_sE, a_sM}, 4'b1111);
      chk($sformatf("mw%0d_flushW", i), a_flW, 1);
      chk($sformatf("mw%0d_flushD", i), a_flD, 0);
      tick();
      if (i == 0) chk("mw_state_wait", 32'(u_a.r_state), 32'(ST_WAIT));
    end
    memReadyM = 1; settle();
    chk("mw_done_stall", {a_sF, a_sD, a_sE, a_sM}, 4'b0000);
    chk("mw_done_flushW", a_flW, 0);
    chk("mw_done_flushD", a_flD, 1);
    tick();
    idle();
    chk("mw_state_run", 32'(u_a.r_state), 32'(ST_RUN));
    chk("mw_stallCnt", a_sCnt, 7);
    chk("mw_flushCnt", a_fCnt, 6);
    chk("mw_memErr_a", a_err, 0);
    chk("mw_memErr_b", b_err, 0);

    // ---- memory wait, 6 cycles: timeout on u_b only ----
    memReqM = 1; memReadyM = 0;
    for (int i = 0; i < 6; i++) tick();
    memReadyM = 1; settle();
    chk("to_memErr_b", b_err, 1);
    chk("to_memErr_a", a_err, 0);
    tick();
    idle();
    tick();
    chk("to_sticky_b", b_err, 1);
    chk("to_stallCnt", a_sCnt, 13);

    // ---- counter saturation ----
    memToRegE = 1; rdE = 5; rs1D = 5; settle();
    for (int i = 0; i < 20; i++) tick();
    idle();
    chk("sat_b_stallCnt", b_sCnt, 4'hF);
    chk("sat_b_flushCnt", b_fCnt, 4'hF);
    chk("sat_a_stallCnt", a_sCnt, 33);
    chk("sat_a_flushCnt", a_fCnt, 26);

    // ---- reset mid-WAIT ----
    memReqM = 1; memReadyM = 0;
    tick(); tick();
    chk("rw_state_wait", 32'(u_a.r_state), 32'(ST_WAIT));
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    idle();
    chk("rw_state_run", 32'(u_a.r_state), 32'(ST_RUN));
    chk("rw_stallCnt", a_sCnt, 0);
    chk("rw_flushCnt", a_fCnt, 0);
    chk("rw_memErr_b", b_err, 0);
    chk("rw_stall_idle", {a_sF, a_sD, a_sE, a_sM, a_flD, a_flE, a_flW}, 7'b0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
